// File: rtl/command_deserializer_if.sv
// Byte-stream input and decoded register-write output of command_deserializer.
// The deserializer sits on the slave side; the byte source/command sink is the master.
interface command_deserializer_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
);
   logic [7:0]            byte_i;
   logic                  byte_valid_i;
   logic                  byte_ready_o;
   logic [ADDR_WIDTH-1:0] addr_o;
   logic [DATA_WIDTH-1:0] data_o;
   logic                  valid_o;
   logic                  err_o;
   logic [7:0]            err_count_o;

   modport master (
      output byte_i,
      output byte_valid_i,
      input  byte_ready_o,
      input  addr_o,
      input  data_o,
      input  valid_o,
      input  err_o,
      input  err_count_o
   );

   modport slave (
      input  byte_i,
      input  byte_valid_i,
      output byte_ready_o,
      output addr_o,
      output data_o,
      output valid_o,
      output err_o,
      output err_count_o
   );
endinterface

// File: rtl/command_deserializer.sv
// Decodes SYNC/2 address/4 data bytes into a one-cycle register write strobe.
// Define CMD_DESERIALIZER_CHECKSUM_EN to add a trailing checksum byte and its check.
module command_deserializer #(
   parameter int         ADDR_WIDTH     = 16,
   parameter int         DATA_WIDTH     = 32,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input logic                   clk,
   input logic                   rst_n_i,
   command_deserializer_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, CSUM, EMIT} state_e;

   state_e                state_q, state_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [15:0]           addr_sr_q, addr_sr_d;
   logic [31:0]           data_sr_q, data_sr_d;
   logic [TW-1:0]         idle_q, idle_d;
   logic                  ready_q, ready_d;
   logic                  valid_q, valid_d;
   logic                  err_q, err_d;
   logic [7:0]            err_cnt_q, err_cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;

   logic accept;
   logic in_frame;
   logic next_in_frame;
   logic timeout;
   logic csum_bad;

   assign accept        = bus.byte_valid_i & ready_q;
   assign in_frame      = (state_q == ADDR) || (state_q == DATA) || (state_q == CSUM);
   assign next_in_frame = (state_d == ADDR) || (state_d == DATA) || (state_d == CSUM);
   // An accepted byte in the expiry cycle suppresses the timeout.
   assign timeout       = in_frame && !accept && (idle_q == TW'(TIMEOUT_CYCLES - 1));

`ifdef CMD_DESERIALIZER_CHECKSUM_EN
   logic [7:0] sum_q, sum_d;
   logic [7:0] csum_total;

   assign csum_total = sum_q + bus.byte_i;
   assign csum_bad   = (state_q == CSUM) && accept && (csum_total != 8'h00);
`else
   assign csum_bad   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (timeout) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (accept && (bus.byte_i == SYNC_BYTE)) state_d = ADDR;
            ADDR: if (accept && (cnt_q == 2'd1)) state_d = DATA;
            DATA: if (accept && (cnt_q == 2'd3)) begin
`ifdef CMD_DESERIALIZER_CHECKSUM_EN
               state_d = CSUM;
`else
               state_d = EMIT;
`endif
            end
            CSUM: if (accept) state_d = csum_bad ? IDLE : EMIT;
            EMIT: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_d     = cnt_q;
      addr_sr_d = addr_sr_q;
      data_sr_d = data_sr_q;
      addr_d    = addr_q;
      data_d    = data_q;
      idle_d    = idle_q;
      if (accept && (state_q == ADDR)) addr_sr_d = {addr_sr_q[7:0], bus.byte_i};
      if (accept && (state_q == DATA)) data_sr_d = {data_sr_q[23:0], bus.byte_i};
      if (state_d != state_q) begin
         cnt_d = 2'd0;
      end else if (accept) begin
         cnt_d = cnt_q + 2'd1;
      end
      if (accept || !next_in_frame) begin
         idle_d = '0;
      end else begin
         idle_d = idle_q + TW'(1);
      end
      ready_d   = (state_d != EMIT);
      valid_d   = (state_d == EMIT);
      err_d     = timeout | csum_bad;
      err_cnt_d = (err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
      // Without a checksum byte the last data byte lands in the same cycle EMIT is entered.
      if (state_d == EMIT) begin
         addr_d = ADDR_WIDTH'(addr_sr_q);
         data_d = DATA_WIDTH'(data_sr_d);
      end
`ifdef CMD_DESERIALIZER_CHECKSUM_EN
      sum_d = sum_q;
      if (state_q == IDLE) begin
         sum_d = 8'h00;
      end else if (accept && ((state_q == ADDR) || (state_q == DATA))) begin
         sum_d = sum_q + bus.byte_i;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q     <= 2'd0;
         addr_sr_q <= 16'h0000;
         data_sr_q <= 32'h0000_0000;
         idle_q    <= '0;
         ready_q   <= 1'b0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= 8'h00;
         addr_q    <= '0;
         data_q    <= '0;
`ifdef CMD_DESERIALIZER_CHECKSUM_EN
         sum_q     <= 8'h00;
`endif
      end else begin
         cnt_q     <= cnt_d;
         addr_sr_q <= addr_sr_d;
         data_sr_q <= data_sr_d;
         idle_q    <= idle_d;
         ready_q   <= ready_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
`ifdef CMD_DESERIALIZER_CHECKSUM_EN
         sum_q     <= sum_d;
`endif
      end
   end

   assign bus.byte_ready_o = ready_q;
   assign bus.valid_o      = valid_q;
   assign bus.err_o        = err_q;
   assign bus.err_count_o  = err_cnt_q;
   assign bus.addr_o       = addr_q;
   assign bus.data_o       = data_q;
endmodule

// File: tb/tb_command_deserializer.sv
// Self-checking bench for command_deserializer: directed vector table, corner-case
// sequences and randomized frames scored against a frame-level reference model.
module tb_command_deserializer;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int T1 = 1024;
   localparam int T2 = 8;
   localparam logic [7:0] SYNC = 8'hA5;
`ifdef CMD_DESERIALIZER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   typedef struct packed {
      logic [79:0]   bytes;
      logic [7:0]    nbytes;
      logic          exp_valid;
      logic          exp_err;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_data;
      logic [7:0]    exp_errcnt;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n_i;
   logic [7:0] drv_byte;
   logic       drv_valid;
   logic       sel2;

   int checks = 0;
   int errors = 0;
   int mon_valid = 0;
   int mon_err = 0;
   int vbase;
   int ebase;

   logic [15:0] last_addr;
   logic [31:0] last_data;
   int          errcnt_model;
   int          errcnt2_model;

   always #5 clk = ~clk;

   command_deserializer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
   command_deserializer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

   assign bus.byte_i        = drv_byte;
   assign bus.byte_valid_i  = drv_valid & ~sel2;
   assign bus2.byte_i       = drv_byte;
   assign bus2.byte_valid_i = drv_valid & sel2;

   command_deserializer #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(T1)
   ) dut (
      .clk(clk), .rst_n_i(rst_n_i), .bus(bus.slave)
   );

   command_deserializer #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(T2)
   ) dut2 (
      .clk(clk), .rst_n_i(rst_n_i), .bus(bus2.slave)
   );

   always @(negedge clk) begin
      if (bus.valid_o) mon_valid = mon_valid + 1;
      if (bus.err_o) mon_err = mon_err + 1;
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic idleCycles(input int n);
      drv_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge right after the byte was accepted.
   task automatic applyStimulus(input logic [7:0] b);
      int guard;
      guard = 0;
      drv_byte  = b;
      drv_valid = 1'b1;
      while (!(sel2 ? bus2.byte_ready_o : bus.byte_ready_o) && guard < 16) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 16) checkOutput("ready_wait", 64'd0, 64'd1);
      @(negedge clk);
      drv_valid = 1'b0;
   endtask

   task automatic snap();
      vbase = mon_valid;
      ebase = mon_err;
   endtask

   task automatic sendFrame(input logic [15:0] a, input logic [31:0] d, input bit bad,
                            input int maxgap, output bit ok);
      logic [7:0] p [6];
      logic [7:0] cs;
      int sum;
      p[0] = a[15:8];  p[1] = a[7:0];
      p[2] = d[31:24]; p[3] = d[23:16]; p[4] = d[15:8]; p[5] = d[7:0];
      sum = 0;
      applyStimulus(SYNC);
      for (int i = 0; i < 6; i++) begin
         sum += int'(p[i]);
         idleCycles($urandom_range(0, maxgap));
         applyStimulus(p[i]);
      end
      ok = 1'b1;
      if (CSUM_EN) begin
         cs = 8'((256 - (sum % 256)) % 256);
         if (bad) cs = cs + 8'($urandom_range(1, 255));
         ok = (((sum + int'(cs)) % 256) == 0);
         idleCycles($urandom_range(0, maxgap));
         applyStimulus(cs);
      end
   endtask

   task automatic expectFrame(input bit ok, input logic [15:0] a, input logic [31:0] d);
      checkOutput("valid_latency", 64'(bus.valid_o), 64'(ok));
      checkOutput("err_pulse", 64'(bus.err_o), 64'(!ok));
      checkOutput("ready_bubble", 64'(bus.byte_ready_o), 64'(!ok));
      if (ok) begin
         last_addr = a;
         last_data = d;
      end else if (errcnt_model < 255) begin
         errcnt_model++;
      end
      idleCycles(1);
      checkOutput("valid_one_cycle", 64'(bus.valid_o), 64'd0);
      checkOutput("err_one_cycle", 64'(bus.err_o), 64'd0);
      checkOutput("ready_back", 64'(bus.byte_ready_o), 64'd1);
      checkOutput("addr", 64'(bus.addr_o), 64'(last_addr));
      checkOutput("data", 64'(bus.data_o), 64'(last_data));
      checkOutput("err_count", 64'(bus.err_count_o), 64'(errcnt_model));
      checkOutput("valid_pulses", 64'(mon_valid - vbase), 64'(ok));
      checkOutput("err_pulses", 64'(mon_err - ebase), 64'(!ok));
   endtask

   vec_t       vecs [3];
   vec_t       v;
   bit         ok;
   logic [15:0] ra;
   logic [31:0] rd;
   logic [7:0]  gb;
   bit          bad;
   int          ng;

   initial begin
`ifdef CMD_DESERIALIZER_CHECKSUM_EN
      vecs[0] = '{bytes: {8'hA5, 8'h00, 8'h60, 8'h00, 8'h00, 8'h01, 8'h2C, 8'h73, 16'h0000},
                  nbytes: 8'd8, exp_valid: 1'b1, exp_err: 1'b0, exp_addr: 16'h0060,
                  exp_data: 32'h0000_012C, exp_errcnt: 8'd0};
      vecs[1] = '{bytes: {8'hA5, 8'h00, 8'h60, 8'h00, 8'h00, 8'h01, 8'h2C, 8'h74, 16'h0000},
                  nbytes: 8'd8, exp_valid: 1'b0, exp_err: 1'b1, exp_addr: 16'h0060,
                  exp_data: 32'h0000_012C, exp_errcnt: 8'd1};
      vecs[2] = '{bytes: {8'h00, 8'hFF, 8'hA5, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h82},
                  nbytes: 8'd10, exp_valid: 1'b1, exp_err: 1'b0, exp_addr: 16'h1234,
                  exp_data: 32'hDEAD_BEEF, exp_errcnt: 8'd1};
`else
      vecs[0] = '{bytes: {8'hA5, 8'h00, 8'h60, 8'h00, 8'h00, 8'h01, 8'h2C, 24'h000000},
                  nbytes: 8'd7, exp_valid: 1'b1, exp_err: 1'b0, exp_addr: 16'h0060,
                  exp_data: 32'h0000_012C, exp_errcnt: 8'd0};
      vecs[1] = '{bytes: {8'hA5, 8'hA5, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h01, 24'h000000},
                  nbytes: 8'd7, exp_valid: 1'b1, exp_err: 1'b0, exp_addr: 16'hA500,
                  exp_data: 32'h00A5_0001, exp_errcnt: 8'd0};
      vecs[2] = '{bytes: {8'h00, 8'hFF, 8'hA5, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00},
                  nbytes: 8'd9, exp_valid: 1'b1, exp_err: 1'b0, exp_addr: 16'h1234,
                  exp_data: 32'hDEAD_BEEF, exp_errcnt: 8'd0};
`endif

      // Reset values while held in reset, then ready on the first edge after release.
      rst_n_i   = 1'b0;
      drv_byte  = 8'h00;
      drv_valid = 1'b0;
      sel2      = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_ready", 64'(bus.byte_ready_o), 64'd0);
      checkOutput("rst_valid", 64'(bus.valid_o), 64'd0);
      checkOutput("rst_err", 64'(bus.err_o), 64'd0);
      checkOutput("rst_addr", 64'(bus.addr_o), 64'd0);
      checkOutput("rst_data", 64'(bus.data_o), 64'd0);
      checkOutput("rst_errcnt", 64'(bus.err_count_o), 64'd0);
      rst_n_i = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_rst", 64'(bus.byte_ready_o), 64'd1);
      checkOutput("ready2_after_rst", 64'(bus2.byte_ready_o), 64'd1);

      // Directed vector table.
      for (int k = 0; k < 3; k++) begin
         v = vecs[k];
         snap();
         for (int b = 0; b < int'(v.nbytes); b++) applyStimulus(v.bytes[79 - 8*b -: 8]);
         checkOutput("vec_valid", 64'(bus.valid_o), 64'(v.exp_valid));
         checkOutput("vec_err", 64'(bus.err_o), 64'(v.exp_err));
         idleCycles(1);
         checkOutput("vec_valid_gone", 64'(bus.valid_o), 64'd0);
         checkOutput("vec_addr", 64'(bus.addr_o), 64'(v.exp_addr));
         checkOutput("vec_data", 64'(bus.data_o), 64'(v.exp_data));
         checkOutput("vec_errcnt", 64'(bus.err_count_o), 64'(v.exp_errcnt));
         checkOutput("vec_valid_pulses", 64'(mon_valid - vbase), 64'(v.exp_valid));
         checkOutput("vec_err_pulses", 64'(mon_err - ebase), 64'(v.exp_err));
         last_addr    = v.exp_addr;
         last_data    = v.exp_data;
         errcnt_model = int'(v.exp_errcnt);
      end

      // Mid-frame timeout at exactly TIMEOUT_CYCLES idle cycles, then recovery.
      snap();
      applyStimulus(SYNC);
      applyStimulus(8'h00);
      idleCycles(T1 - 1);
      checkOutput("timeout_early", 64'(bus.err_o), 64'd0);
      idleCycles(1);
      checkOutput("timeout_err", 64'(bus.err_o), 64'd1);
      if (errcnt_model < 255) errcnt_model++;
      idleCycles(1);
      checkOutput("timeout_errcnt", 64'(bus.err_count_o), 64'(errcnt_model));
      checkOutput("timeout_no_valid", 64'(mon_valid - vbase), 64'd0);
      snap();
      sendFrame(16'h0060, 32'h0000_012C, 1'b0, 0, ok);
      expectFrame(ok, 16'h0060, 32'h0000_012C);

      // Reset in the middle of a frame after the third data byte.
      snap();
      applyStimulus(SYNC);
      applyStimulus(8'hAB); applyStimulus(8'hCD);
      applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
      rst_n_i = 1'b0;
      #1;
      checkOutput("midrst_ready", 64'(bus.byte_ready_o), 64'd0);
      checkOutput("midrst_addr", 64'(bus.addr_o), 64'd0);
      checkOutput("midrst_data", 64'(bus.data_o), 64'd0);
      checkOutput("midrst_errcnt", 64'(bus.err_count_o), 64'd0);
      repeat (2) @(negedge clk);
      rst_n_i = 1'b1;
      @(negedge clk);
      checkOutput("midrst_ready_back", 64'(bus.byte_ready_o), 64'd1);
      checkOutput("midrst_no_valid", 64'(mon_valid - vbase), 64'd0);
      checkOutput("midrst_no_err", 64'(mon_err - ebase), 64'd0);
      errcnt_model = 0;
      last_addr    = 16'h0000;
      last_data    = 32'h0000_0000;
      snap();
      sendFrame(16'hBEEF, 32'hCAFE_F00D, 1'b0, 0, ok);
      expectFrame(ok, 16'hBEEF, 32'hCAFE_F00D);

      // Short-timeout instance: a byte accepted in the expiry cycle wins.
      sel2 = 1'b1;
      errcnt2_model = 0;
      applyStimulus(SYNC);
      idleCycles(T2 - 1);
      applyStimulus(8'h12);
      checkOutput("boundary_no_err", 64'(bus2.err_o), 64'd0);
      applyStimulus(8'h34); applyStimulus(8'hDE); applyStimulus(8'hAD);
      applyStimulus(8'hBE); applyStimulus(8'hEF);
`ifdef CMD_DESERIALIZER_CHECKSUM_EN
      applyStimulus(8'h82);
`endif
      checkOutput("boundary_valid", 64'(bus2.valid_o), 64'd1);
      checkOutput("boundary_addr", 64'(bus2.addr_o), 64'h1234);
      checkOutput("boundary_data", 64'(bus2.data_o), 64'hDEAD_BEEF);
      checkOutput("boundary_errcnt", 64'(bus2.err_count_o), 64'd0);
      idleCycles(1);

      // Repeated timeouts saturate the error counter without wrapping.
      for (int i = 0; i < 300; i++) begin
         applyStimulus(SYNC);
         idleCycles(T2 - 1);
         if (i == 0) checkOutput("t2_not_yet", 64'(bus2.err_o), 64'd0);
         idleCycles(1);
         checkOutput("t2_err_pulse", 64'(bus2.err_o), 64'd1);
         if (errcnt2_model < 255) errcnt2_model++;
         idleCycles(1);
         if ((i % 50) == 0 || i >= 253) checkOutput("t2_errcnt", 64'(bus2.err_count_o), 64'(errcnt2_model));
      end
      checkOutput("t2_saturated", 64'(bus2.err_count_o), 64'hFF);
      sel2 = 1'b0;

      // Randomized frames with garbage prefixes, gaps and occasional bad checksums.
      for (int f = 0; f < 40; f++) begin
         snap();
         ng = $urandom_range(0, 3);
         for (int g = 0; g < ng; g++) begin
            gb = 8'($urandom_range(0, 255));
            if (gb == SYNC) gb = 8'h5A;
            applyStimulus(gb);
         end
         ra  = 16'($urandom);
         rd  = $urandom;
         if ($urandom_range(0, 4) == 0) ra[15:8] = SYNC;
         bad = CSUM_EN && ($urandom_range(0, 3) == 0);
         sendFrame(ra, rd, bad, 2, ok);
         expectFrame(ok, ra, rd);
      end

`ifdef CMD_DESERIALIZER_CHECKSUM_EN
      // Bad-checksum frames saturate the main instance's error counter.
      for (int i = 0; i < 300; i++) begin
         snap();
         sendFrame(16'h0060, 32'h0000_012C, 1'b1, 0, ok);
         expectFrame(ok, 16'h0060, 32'h0000_012C);
      end
      checkOutput("csum_saturated", 64'(bus.err_count_o), 64'hFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/command_deserializer.md
COMMAND_DESERIALIZER -- requirements
Module: command_deserializer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: width of the emitted command address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of the emitted command data.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum idle cycles allowed mid-frame.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port byte_i, input, 8 bits: serial command byte.
REQ-008 SHALL have port byte_valid_i, input, 1 bit: byte_i is valid.
REQ-009 SHALL have port byte_ready_o, output, 1 bit: block can accept a byte.
REQ-010 SHALL have port addr_o, output, ADDR_WIDTH bits: decoded register address, feeding the controller write port.
REQ-011 SHALL have port data_o, output, DATA_WIDTH bits: decoded register data.
REQ-012 SHALL have port valid_o, output, 1 bit: one-cycle write strobe.
REQ-013 SHALL have port err_o, output, 1 bit: one-cycle frame-error pulse.
REQ-014 SHALL have port err_count_o, output, 8 bits: saturating frame-error counter.

Function
REQ-015 SHALL accept a byte only in a cycle where byte_valid_i and byte_ready_o are both 1.
REQ-016 SHALL implement the states IDLE, ADDR, DATA, CSUM and EMIT.
REQ-017 SHALL discard non-SYNC_BYTE bytes in IDLE silently; on an accepted SYNC_BYTE it SHALL move to ADDR.
REQ-018 SHALL collect 2 address bytes in ADDR, MSB first, then move to DATA; address bits above bit 15 SHALL be 0.
REQ-019 SHALL collect 4 data bytes in DATA, MSB first, then move to CSUM; the data value is truncated/zero-extended to DATA_WIDTH.
REQ-020 SHALL, in CSUM, check the accepted byte: the 8-bit modulo-256 sum of the 6 payload bytes plus the checksum byte must equal 8'h00.
REQ-021 SHALL, on a checksum pass, move to EMIT.
REQ-022 SHALL, on a checksum fail, pulse err_o for 1 cycle, not assert valid_o, and return to IDLE.
REQ-023 SHALL, in EMIT, update addr_o/data_o and assert valid_o for exactly 1 cycle, then return to IDLE.
REQ-024 SHALL assert valid_o on the cycle after the final byte is accepted (latency 1).
REQ-025 SHALL hold addr_o/data_o stable until the next EMIT.
REQ-026 SHALL drive byte_ready_o=1 in all states except EMIT, giving a one-cycle bubble per frame.
REQ-027 SHALL count consecutive cycles without an accepted byte in ADDR, DATA and CSUM; the count resets on every accepted byte and on entry to ADDR.
REQ-028 SHALL, when that count reaches TIMEOUT_CYCLES, return to IDLE, pulse err_o and discard the partial frame.
REQ-029 SHALL let an accepted byte win when it occurs in the same cycle the timeout count would expire.
REQ-030 SHALL treat a SYNC_BYTE value received mid-frame as payload, not as a resync.
REQ-031 SHALL increment err_count_o on every err_o pulse, saturating at 8'hFF.

Reset
REQ-032 SHALL, while rst_n_i=0, immediately force state IDLE, addr_o=0, data_o=0, valid_o=0, err_o=0, err_count_o=0, byte_ready_o=0 and timeout count=0.
REQ-033 SHALL drive byte_ready_o=1 from the first clock edge after rst_n_i is released.
REQ-034 SHALL discard a partially received frame when reset is asserted mid-frame, with no valid_o or err_o.

Configuration
REQ-035 SHALL, with macro CMD_DESERIALIZER_CHECKSUM_EN defined, implement the CSUM state and checksum check as above.
REQ-036 SHALL, without that macro, omit CSUM: after the 4th data byte it moves to EMIT, frames are 7 bytes, and err_o is caused only by timeout.

Verification
REQ-037 SHALL cover: frame A5 00 60 00 00 01 2C 73 (macro on) -> valid_o for 1 cycle, addr_o=16'h0060, data_o=32'h0000012C, err_count_o=0.
REQ-038 SHALL cover: same frame with checksum 74 -> err_o pulse, no valid_o, err_count_o=1.
REQ-039 SHALL cover: bytes 00 FF A5 followed by a valid frame body -> leading garbage ignored, exactly one valid_o.
REQ-040 SHALL cover: A5 00, then byte_valid_i=0 for 1024 cycles -> err_o pulse, state IDLE; a following complete frame is decoded correctly.
REQ-041 SHALL cover: 300 bad-checksum frames -> err_count_o=8'hFF, with no wrap.
REQ-042 SHALL cover: rst_n_i pulsed low after the 3rd data byte -> no valid_o or err_o; all outputs 0; a following frame decodes normally.
